// File: rtl/md5_block_ctrl_pkg.sv
// Shared MD5 constants and helpers for the block sequencer and the step datapath.
package md5_block_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  // K[i] = floor(|sin(i+1)| * 2^32)
  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts, indexed by {round, step[1:0]}
  localparam logic [4:0] SHIFT [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  // Message word index for step i; only i mod 16 matters inside each round
  function automatic logic [3:0] g_idx(input logic [5:0] i);
    logic [3:0] j;
    j = i[3:0];
    case (i[5:4])
      2'd0:    g_idx = j;
      2'd1:    g_idx = 4'(j * 4'd5 + 4'd1);
      2'd2:    g_idx = 4'(j * 4'd3 + 4'd5);
      default: g_idx = 4'(j * 4'd7);
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    rotl = (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

endpackage

// File: rtl/md5_block_ctrl_if.sv
// Word-input / hash-output bus between the message source and the block sequencer.
interface md5_block_ctrl_if;
  logic          init;
  logic          rdy;
  logic [0:31]   msg;
  logic [0:127]  hash_o;
  logic          rdy_o;
  logic          busy_o;

  modport master (output init, rdy, msg, input hash_o, rdy_o, busy_o);
  modport slave  (input init, rdy, msg, output hash_o, rdy_o, busy_o);
endinterface

// File: rtl/md5_block_ctrl_core.sv
// md5_core: one combinational MD5 step, a_o = b + rotl(a + F(b,c,d) + m + t, s).
module md5_core
  import md5_block_ctrl_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] m_i,
  input  logic [31:0] t_i,
  input  logic [4:0]  s_i,
  input  logic [1:0]  round_i,
  output logic [31:0] a_o
);
  logic [31:0] f, sum;

  // Round function select, then add/rotate/add
  always_comb begin
    f = '0;
    case (round_i)
      2'd0:    f = (b_i & c_i) | (~b_i & d_i);
      2'd1:    f = (b_i & d_i) | (c_i & ~d_i);
      2'd2:    f = b_i ^ c_i ^ d_i;
      default: f = c_i ^ (b_i | ~d_i);
    endcase
    sum = a_i + f + m_i + t_i;
    a_o = b_i + rotl(sum, s_i);
  end
endmodule

// File: rtl/md5_block_ctrl.sv
// md5_block_ctrl: buffers a 16-word block, runs 64 md5_core steps (one per clock),
// folds the result into the chaining state and publishes the 128-bit hash.
module md5_block_ctrl
  import md5_block_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  md5_block_ctrl_if.slave bus
);
  state_e       state_q;
  logic [3:0]   cnt_q;
  logic [5:0]   step_q;
  logic [31:0]  msg_q [16];
  logic [31:0]  ha_q, hb_q, hc_q, hd_q;   // chaining value
  logic [31:0]  a_q, b_q, c_q, d_q;       // working registers
  logic [127:0] hash_q;
  logic         rdy_q, busy_q;
  logic [3:0]   wr_idx;
  logic [31:0]  core_a;

  // init restarts the word count, so a word arriving with it lands in M[0]
  always_comb begin
    wr_idx = bus.init ? 4'd0 : cnt_q;
  end

  md5_core u_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .c_i     (c_q),
    .d_i     (d_q),
    .m_i     (msg_q[g_idx(step_q)]),
    .t_i     (K[step_q]),
    .s_i     (SHIFT[{step_q[5:4], step_q[1:0]}]),
    .round_i (step_q[5:4]),
    .a_o     (core_a)
  );

  // Message buffer: written only in LOAD; contents need no reset since cnt gates use
  always_ff @(posedge clk) begin
    if (rst && state_q == ST_LOAD && bus.rdy)
      msg_q[wr_idx] <= bus.msg;
  end

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      step_q  <= '0;
      ha_q    <= IV_A;
      hb_q    <= IV_B;
      hc_q    <= IV_C;
      hd_q    <= IV_D;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      hash_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (bus.init) begin
            ha_q <= IV_A;
            hb_q <= IV_B;
            hc_q <= IV_C;
            hd_q <= IV_D;
          end
          if (bus.rdy) begin
            cnt_q <= wr_idx + 4'd1;   // wraps to 0 after word 15
            if (wr_idx == 4'd15) begin
              // word 15 cannot coincide with init, so chaining is current here
              a_q     <= ha_q;
              b_q     <= hb_q;
              c_q     <= hc_q;
              d_q     <= hd_q;
              step_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= ST_ROUND;
            end
          end else if (bus.init) begin
            cnt_q <= '0;
          end
        end
        ST_ROUND: begin
          a_q    <= d_q;
          b_q    <= core_a;
          c_q    <= b_q;
          d_q    <= c_q;
          step_q <= step_q + 6'd1;
          if (step_q == 6'd63)
            state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          ha_q    <= ha_q + a_q;
          hb_q    <= hb_q + b_q;
          hc_q    <= hc_q + c_q;
          hd_q    <= hd_q + d_q;
          hash_q  <= {ha_q + a_q, hb_q + b_q, hc_q + c_q, hd_q + d_q};
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_LOAD;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign bus.hash_o = hash_q;
  assign bus.rdy_o  = rdy_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_md5_block_ctrl.sv
// Bench for md5_block_ctrl: cycle-level behavioural model with a software MD5
// compression function, checked every cycle, plus literal known-answer hashes.
module tb_md5_block_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  md5_block_ctrl_if bus();

  md5_block_ctrl dut (.clk(clk), .rst(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  localparam logic [127:0] IV = 128'h67452301_efcdab89_98badcfe_10325476;

  int checks = 0;
  int errors = 0;

  bit [31:0] kt [64];
  int        sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  // model state
  int           m_cnt, m_busy;
  bit [31:0]    m_buf [16];
  bit [31:0]    m_blk [16];
  logic [127:0] m_chain, m_hash;
  logic         m_rdy;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] rl(input bit [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [127:0] compress(input logic [127:0] h, input bit [31:0] w [16]);
    bit [31:0] a, b, c, d, f, t;
    int g;
    a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); g = i; end
        1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      endcase
      t = d; d = c; c = b;
      b = b + rl(a + f + kt[i] + w[g], sh[i / 16][i % 4]);
      a = t;
    end
    return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
  endfunction

  // One clock edge of the specified behaviour, from the inputs present at the edge
  task automatic model_edge();
    if (!rst_n) begin
      m_cnt = 0; m_chain = IV; m_hash = '0; m_rdy = 0; m_busy = 0;
    end else begin
      m_rdy = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_chain = compress(m_chain, m_blk);
          m_hash  = m_chain;
          m_rdy   = 1;
        end
      end else begin
        if (bus.init) begin m_chain = IV; m_cnt = 0; end
        if (bus.rdy) begin
          m_buf[m_cnt] = bus.msg;
          if (m_cnt == 15) begin m_blk = m_buf; m_busy = 65; m_cnt = 0; end
          else m_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("busy_o", 128'(bus.busy_o), 128'(m_busy != 0));
    check("rdy_o", 128'(bus.rdy_o), 128'(m_rdy));
    check("hash_o", bus.hash_o, m_hash);
  endtask

  // Send a block (optionally with init alongside word 0), then wait for the result
  task automatic send_block(input bit [31:0] w [16], input bit with_init, input int gap_pct,
                            input bit junk);
    int n, busy_n;
    bit got;
    for (int k = 0; k < 16; k++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.rdy = 0; bus.init = 0; bus.msg = $urandom; step();
      end
      bus.rdy = 1; bus.msg = w[k]; bus.init = with_init && (k == 0);
      step();
    end
    busy_n = bus.busy_o ? 1 : 0;
    n = 0; got = 0;
    while (!got && n < 200) begin
      bus.rdy  = junk && (m_busy > 0);
      bus.init = junk && (m_busy > 0) && $urandom_range(1);
      bus.msg  = $urandom;
      step();
      n++;
      if (bus.busy_o) busy_n++;
      if (bus.rdy_o) got = 1;
    end
    bus.rdy = 0; bus.init = 0;
    check("result_seen", 128'(got), 128'(1));
    check("latency_edges", 128'(n), 128'(65));
    check("busy_cycles", 128'(busy_n), 128'(65));
  endtask

  bit [31:0] blk_empty [16];
  bit [31:0] blk_abc   [16];
  bit [31:0] b1 [16];
  bit [31:0] b2 [16];
  logic [127:0] h1, exp2;
  bit saw_rdy;

  initial begin
    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    for (int i = 0; i < 16; i++) begin blk_empty[i] = 0; blk_abc[i] = 0; end
    blk_empty[0] = 32'h00000080;
    blk_abc[0] = 32'h80636261; blk_abc[14] = 32'h00000018;

    // pin the software model against known digests
    check("model_empty", compress(IV, blk_empty), 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec);
    check("model_abc", compress(IV, blk_abc), 128'h98500190_b04fd23c_7d3f96d6_727fe128);

    // reset with junk on the inputs
    rst_n = 0; bus.init = 0; bus.rdy = 0; bus.msg = '0;
    for (int i = 0; i < 6; i++) begin
      bus.rdy = $urandom_range(1); bus.init = $urandom_range(1); bus.msg = $urandom;
      step();
    end
    check("reset_hash", bus.hash_o, 128'h0);
    rst_n = 1; bus.rdy = 0; bus.init = 0;
    step();

    // empty-string block after a standalone init
    bus.init = 1; step(); bus.init = 0;
    send_block(blk_empty, 0, 0, 0);
    check("empty_hash", bus.hash_o, 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec);

    // "abc" with init alongside word 0 and random gaps
    send_block(blk_abc, 1, 40, 0);
    check("abc_hash", bus.hash_o, 128'h98500190_b04fd23c_7d3f96d6_727fe128);

    // "abc" with junk words and init driven throughout the rounds
    send_block(blk_abc, 1, 0, 1);
    check("abc_junk_hash", bus.hash_o, 128'h98500190_b04fd23c_7d3f96d6_727fe128);

    // abort at step 30, then a clean "abc"
    bus.init = 1;
    for (int k = 0; k < 16; k++) begin bus.rdy = 1; bus.msg = blk_abc[k]; step(); bus.init = 0; end
    bus.rdy = 0;
    saw_rdy = 0;
    for (int i = 0; i < 30; i++) begin step(); if (bus.rdy_o) saw_rdy = 1; end
    rst_n = 0; step(); rst_n = 1;
    for (int i = 0; i < 80; i++) begin step(); if (bus.rdy_o) saw_rdy = 1; end
    check("abort_no_rdy", 128'(saw_rdy), 128'(0));
    check("abort_hash_cleared", bus.hash_o, 128'h0);
    send_block(blk_abc, 1, 20, 0);
    check("abc_after_abort", bus.hash_o, 128'h98500190_b04fd23c_7d3f96d6_727fe128);

    // two chained blocks, no init between
    for (int i = 0; i < 16; i++) begin b1[i] = $urandom; b2[i] = $urandom; end
    exp2 = compress(compress(IV, b1), b2);
    send_block(b1, 1, 10, 0);
    send_block(b2, 0, 10, 0);
    check("chain2_hash", bus.hash_o, exp2);

    // same block twice with init between gives the same hash
    send_block(b1, 1, 10, 0);
    h1 = bus.hash_o;
    send_block(b1, 1, 10, 0);
    check("reinit_equal", bus.hash_o, h1);

    // random traffic: gaps, stray init, occasional reset
    for (int i = 0; i < 4000; i++) begin
      rst_n    = ($urandom_range(299) != 0);
      bus.init = ($urandom_range(39) == 0);
      bus.rdy  = ($urandom_range(99) < 70);
      bus.msg  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
